// File: rtl/led1_prefilter.sv
// LED1 raw-ADC prefilter: drops the first samples while the AFE settles, replaces
// spikes with the previous good sample, then averages groups of 2^DECIM_LOG2 samples.
module led1_prefilter #(
  parameter int unsigned DECIM_LOG2 = 2,
  parameter int unsigned DISCARD_N  = 8,
  parameter logic [21:0] SPIKE_TH   = 22'd200000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [21:0] adc_data,
  input  logic               adc_valid,
  output logic signed [21:0] led1,
  output logic               out_new_samples,
  output logic [7:0]         spike_cnt
);

  localparam int unsigned AW = 22 + DECIM_LOG2;
  localparam int unsigned GW = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
  localparam logic [GW-1:0] GRP_LAST  = GW'((1 << DECIM_LOG2) - 1);
  localparam logic [7:0]    DISC_LAST = 8'(DISCARD_N - 1);

  typedef enum logic {SETTLE, ACCUM} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_disc_cnt;
  logic [GW-1:0]         r_grp_cnt;
  logic signed [AW-1:0]  r_acc;
  logic signed [21:0]    r_prev;
  logic signed [21:0]    r_led1;
  logic                  r_new;
  logic [7:0]            r_spike_cnt;

  logic                  w_disc_last;
  logic                  w_grp_last;
  logic signed [22:0]    w_diff;
  logic [22:0]           w_abs;
  logic                  w_spike;
  logic signed [21:0]    w_sample;
  logic signed [AW-1:0]  w_sum;
  logic signed [21:0]    w_led1;

  // 23-bit difference of two 22-bit values cannot overflow, nor can its magnitude.
  assign w_diff      = 23'(adc_data) - 23'(r_prev);
  assign w_abs       = w_diff[22] ? 23'(-w_diff) : 23'(w_diff);
  assign w_spike     = w_abs > {1'b0, SPIKE_TH};
  assign w_sample    = w_spike ? r_prev : adc_data;
  assign w_sum       = r_acc + AW'(w_sample);
  assign w_led1      = 22'(w_sum >>> DECIM_LOG2);
  assign w_disc_last = (r_disc_cnt == DISC_LAST);
  assign w_grp_last  = (r_grp_cnt == GRP_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= SETTLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SETTLE:  if (adc_valid && w_disc_last) w_state_next = ACCUM;
      ACCUM:   w_state_next = ACCUM;
      default: w_state_next = SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_disc_cnt  <= '0;
      r_grp_cnt   <= '0;
      r_acc       <= '0;
      r_prev      <= '0;
      r_led1      <= '0;
      r_new       <= 1'b0;
      r_spike_cnt <= '0;
    end else begin
      r_new <= 1'b0;
      if (adc_valid) begin
        if (r_state == SETTLE) begin
          if (w_disc_last) r_prev <= adc_data;
          else             r_disc_cnt <= r_disc_cnt + 8'd1;
        end else begin
          if (w_spike) begin
            if (r_spike_cnt != 8'hFF) r_spike_cnt <= r_spike_cnt + 8'd1;
          end else begin
            r_prev <= adc_data;
          end
          if (w_grp_last) begin
            r_led1    <= w_led1;
            r_new     <= 1'b1;
            r_acc     <= '0;
            r_grp_cnt <= '0;
          end else begin
            r_acc     <= w_sum;
            r_grp_cnt <= r_grp_cnt + GW'(1);
          end
        end
      end
    end
  end

  assign led1            = r_led1;
  assign out_new_samples = r_new;
  assign spike_cnt       = r_spike_cnt;

endmodule
